// File: rtl/tone_player.sv
// tone_player: single-clock tone generator. A step counter divides clk50mhz
// by a per-note period from DIV_TABLE; each step advances the sine ROM
// address. Note buttons are synchronised and arbitrated by fixed priority
// (index 0 wins). A released note drains to the end of its waveform cycle.
//
// Ports:
//   clk50mhz  - system clock, rising edge
//   reset_n   - asynchronous active-low reset
//   note_req  - note buttons (asynchronous, active-high)
//   rom_addr  - sine ROM address
//   rom_data  - asynchronous ROM sample for rom_addr
//   tono      - registered audio sample (MID when idle)
//   active    - high while playing or draining
//   cur_note  - latched note index
module tone_player #(
   parameter int NUM_NOTES    = 4,
   parameter int DIV_WIDTH    = 13,
   parameter logic [NUM_NOTES*DIV_WIDTH-1:0] DIV_TABLE =
      {13'h0F92, 13'h1282, 13'h14C8, 13'h1754},
   parameter int ADDR_WIDTH   = 5,
   parameter int SAMPLE_WIDTH = 4,
   parameter bit RETRIGGER    = 1'b0
) (
   input  logic                    clk50mhz,
   input  logic                    reset_n,
   input  logic [NUM_NOTES-1:0]    note_req,
   output logic [ADDR_WIDTH-1:0]   rom_addr,
   input  logic [SAMPLE_WIDTH-1:0] rom_data,
   output logic [SAMPLE_WIDTH-1:0] tono,
   output logic                    active,
   output logic [((NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1)-1:0] cur_note
);

   localparam int NOTE_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
   localparam logic [SAMPLE_WIDTH-1:0] MID = SAMPLE_WIDTH'(1) << (SAMPLE_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, PLAY, RELEASE} state_t;

   state_t                 state, state_nxt;
   logic [NUM_NOTES-1:0]   req_meta, req_s;
   logic [NOTE_W-1:0]      sel, note_nxt;
   logic                   sel_valid, change;
   logic [DIV_WIDTH-1:0]   cnt, cnt_nxt, period, last;
   logic [ADDR_WIDTH-1:0]  addr, addr_nxt;
   logic                   step, wrap;

   // Two-flop synchroniser for the button inputs
   always_ff @(posedge clk50mhz or negedge reset_n) begin
      if (!reset_n) begin
         req_meta <= '0;
         req_s    <= '0;
      end else begin
         req_meta <= note_req;
         req_s    <= req_meta;
      end
   end

   // Fixed priority: lowest set index wins
   always_comb begin
      sel = '0;
      for (int i = NUM_NOTES - 1; i >= 0; i--) begin
         if (req_s[i]) sel = NOTE_W'(i);
      end
   end

   assign sel_valid = |req_s;
   assign change    = sel_valid && (sel != cur_note);

   // Period lookup; entries of 0 or 1 both mean "step every cycle"
   always_comb begin
      period = '0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         if (cur_note == NOTE_W'(i)) period = DIV_TABLE[i*DIV_WIDTH +: DIV_WIDTH];
      end
   end

   assign last = (period > DIV_WIDTH'(1)) ? period - 1'b1 : '0;
   assign step = (cnt == last);
   assign wrap = step && (addr == '1);

   always_comb begin
      state_nxt = state;
      note_nxt  = cur_note;
      cnt_nxt   = cnt;
      addr_nxt  = addr;
      case (state)
         IDLE: begin
            cnt_nxt  = '0;
            addr_nxt = '0;
            if (sel_valid) begin
               state_nxt = PLAY;
               note_nxt  = sel;
            end
         end
         PLAY, RELEASE: begin
            // A note change overrides a coincident step; the phase is kept
            // unless RETRIGGER asks for a fresh waveform start.
            if (change) begin
               note_nxt = sel;
               cnt_nxt  = '0;
               if (RETRIGGER) addr_nxt = '0;
            end else begin
               cnt_nxt  = step ? '0 : cnt + 1'b1;
               addr_nxt = step ? addr + 1'b1 : addr;
            end
            // A re-press beats the end-of-cycle return to IDLE
            if (sel_valid)          state_nxt = PLAY;
            else if (state == PLAY) state_nxt = RELEASE;
            else if (wrap)          state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            addr_nxt  = '0;
         end
      endcase
   end

   always_ff @(posedge clk50mhz or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cur_note <= '0;
         cnt      <= '0;
         addr     <= '0;
         active   <= 1'b0;
      end else begin
         state    <= state_nxt;
         cur_note <= note_nxt;
         cnt      <= cnt_nxt;
         addr     <= addr_nxt;
         active   <= (state_nxt != IDLE);
      end
   end

   // ROM data is valid for the current address; register it so the DAC
   // sees a clean, glitch-free sample one cycle behind rom_addr.
   always_ff @(posedge clk50mhz or negedge reset_n) begin
      if (!reset_n) tono <= MID;
      else          tono <= (state != IDLE) ? rom_data : MID;
   end

   assign rom_addr = addr;

endmodule
